// File: rtl/rr_stream_gearbox_if.sv
// Stream bundle for rr_stream_gearbox: variable-length input units, fixed-width
// output words, and the flush request/acknowledge pair.
interface rr_stream_gearbox_if #(
   parameter int unsigned IN_W  = 256,
   parameter int unsigned OUT_W = 512
);
   localparam int unsigned IN_LEN_W  = $clog2(IN_W + 1);
   localparam int unsigned OUT_LEN_W = $clog2(OUT_W + 1);

   logic                 in_valid;
   logic [IN_W-1:0]      in_data;
   logic [IN_LEN_W-1:0]  in_len;
   logic                 in_ready;
   logic                 flush_req;
   logic                 out_valid;
   logic [OUT_W-1:0]     out_data;
   logic [OUT_LEN_W-1:0] out_len;
   logic                 out_last;
   logic                 out_ready;
   logic                 flush_done;

   modport master (
      output in_valid, in_data, in_len, flush_req, out_ready,
      input  in_ready, out_valid, out_data, out_len, out_last, flush_done
   );

   modport slave (
      input  in_valid, in_data, in_len, flush_req, out_ready,
      output in_ready, out_valid, out_data, out_len, out_last, flush_done
   );
endinterface

// File: rtl/rr_stream_gearbox.sv
// Packs LSB-aligned variable-length units into OUT_W-bit words (bit 0 oldest);
// flush drains a zero-padded partial word flagged with out_last.
module rr_stream_gearbox #(
   parameter int unsigned IN_W  = 256,
   parameter int unsigned OUT_W = 512,
   parameter int unsigned CNT_W = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   rr_stream_gearbox_if.slave bus,
   output logic               len_err,
   output logic [CNT_W-1:0]   bits_in,
   output logic [CNT_W-1:0]   words_out
);
   localparam int unsigned IN_LEN_W  = $clog2(IN_W + 1);
   localparam int unsigned OUT_LEN_W = $clog2(OUT_W + 1);
   localparam int unsigned FILL_W    = $clog2(OUT_W + IN_W + 1);
   localparam int unsigned BUF_W     = OUT_W + IN_W;
   localparam logic [FILL_W-1:0]   OUT_F   = FILL_W'(OUT_W);
   localparam logic [IN_LEN_W-1:0] IN_MAX  = IN_LEN_W'(IN_W);

   typedef enum logic {
      ACCUM,
      FLUSH
   } state_t;

   state_t              state_q, state_d;
   logic [BUF_W-1:0]    buf_q, buf_d;
   logic [FILL_W-1:0]   fill_q, fill_d;
   logic                flush_pend_q, flush_pend_d;
   logic                flush_done_q, flush_done_d;
   logic                len_err_d;
   logic [CNT_W-1:0]    bits_in_d, words_out_d;

   logic                in_ready_c, out_valid_c;
   logic                accept, fire;
   logic [IN_LEN_W-1:0] len_c;
   logic [IN_W-1:0]     masked;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ACCUM;
         buf_q        <= '0;
         fill_q       <= '0;
         flush_pend_q <= 1'b0;
         flush_done_q <= 1'b0;
         len_err      <= 1'b0;
         bits_in      <= '0;
         words_out    <= '0;
      end else begin
         state_q      <= state_d;
         buf_q        <= buf_d;
         fill_q       <= fill_d;
         flush_pend_q <= flush_pend_d;
         flush_done_q <= flush_done_d;
         len_err      <= len_err_d;
         bits_in      <= bits_in_d;
         words_out    <= words_out_d;
      end
   end

   // Handshake outputs depend only on registered state, never on inputs.
   always_comb begin
      in_ready_c  = (state_q == ACCUM) && (fill_q < OUT_F) && !flush_pend_q;
      out_valid_c = (state_q == ACCUM) ? (fill_q >= OUT_F) : (fill_q != '0);
      accept      = bus.in_valid && in_ready_c;
      fire        = out_valid_c && bus.out_ready;
      len_c       = (bus.in_len > IN_MAX) ? IN_MAX : bus.in_len;
      masked      = '0;
      for (int unsigned i = 0; i < IN_W; i++) begin
         if (i < 32'(len_c)) masked[i] = bus.in_data[i];
      end
   end

   always_comb begin
      state_d      = state_q;
      buf_d        = buf_q;
      fill_d       = fill_q;
      flush_pend_d = flush_pend_q | bus.flush_req;
      flush_done_d = 1'b0;
      len_err_d    = len_err;
      bits_in_d    = bits_in;
      words_out_d  = words_out;
      case (state_q)
         ACCUM: begin
            if (accept) begin
               buf_d     = buf_q | (BUF_W'(masked) << fill_q);
               fill_d    = fill_q + FILL_W'(len_c);
               bits_in_d = bits_in + CNT_W'(len_c);
               if (bus.in_len > IN_MAX) len_err_d = 1'b1;
            end
            if (fire) begin
               buf_d       = buf_q >> OUT_W;
               fill_d      = fill_q - OUT_F;
               words_out_d = words_out + 1'b1;
            end
            // Full words drain before a pending flush takes over.
            if (flush_pend_q && (fill_q < OUT_F)) state_d = FLUSH;
         end
         FLUSH: begin
            if (fill_q == '0 || fire) begin
               if (fire) words_out_d = words_out + 1'b1;
               buf_d        = '0;
               fill_d       = '0;
               flush_done_d = 1'b1;
               flush_pend_d = 1'b0;
               state_d      = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   // Bits at and above fill are always zero, so the partial word is padded.
   assign bus.in_ready   = in_ready_c;
   assign bus.out_valid  = out_valid_c;
   assign bus.out_data   = buf_q[OUT_W-1:0];
   assign bus.out_len    = !out_valid_c ? '0 :
                           (state_q == FLUSH) ? fill_q[OUT_LEN_W-1:0] : OUT_LEN_W'(OUT_W);
   assign bus.out_last   = out_valid_c && (state_q == FLUSH);
   assign bus.flush_done = flush_done_q;
endmodule
